// File: rtl/fsm_hold_pkg.sv
// Shared types and constants for the multi-channel hold detector.
// Optional feature macro: FSM_HOLD_AUTOREPEAT_EN (auto-repeat of detections while held).
package fsm_hold_pkg;

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    ST   = 5'b00010,
    HD   = 5'b00100,
    DP   = 5'b01000,
    DT   = 5'b10000
  } state_t;

  // Output bits per state, ordered {START, CLR, Y, Y_PULSE}
  localparam logic [3:0] OUT_IDLE = 4'b0100;
  localparam logic [3:0] OUT_ST   = 4'b1000;
  localparam logic [3:0] OUT_HD   = 4'b0000;
  localparam logic [3:0] OUT_DP   = 4'b0011;
  localparam logic [3:0] OUT_DT   = 4'b0010;

  function automatic int cnt_width(input int hold_cycles, input int repeat_cycles);
    int max_cycles;
    max_cycles = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/fsm_hold_channel.sv
// One hold-detect channel: one-hot Moore FSM plus its hold/repeat counter.
// Optional feature macro: FSM_HOLD_AUTOREPEAT_EN.
module fsm_hold_channel
  import fsm_hold_pkg::*;
#(
  parameter int HOLD_CYCLES   = 4,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic x_i,
  output logic start_o,
  output logic clr_o,
  output logic y_o,
  output logic y_pulse_o
);

`ifdef FSM_HOLD_AUTOREPEAT_EN
  localparam int CW = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
`else
  localparam int CW = cnt_width(HOLD_CYCLES, 1);
`endif
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("fsm_hold_channel: HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  // Plain vector so corrupted (non-one-hot) codes stay representable and recover to IDLE
  logic [4:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    out_bits;

  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    case (state_q)
      IDLE: if (x_i) state_d = ST;
      ST:   state_d = HD;
      HD: begin
        if (!x_i) begin
          state_d = IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = DP;
        end else begin
          state_d = HD;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DP:   state_d = x_i ? DT : IDLE;
      DT: begin
        if (!x_i) begin
          state_d = IDLE;
        end else begin
`ifdef FSM_HOLD_AUTOREPEAT_EN
          if (cnt_q == REPEAT_LAST) begin
            state_d = DP;
          end else begin
            state_d = DT;
            cnt_d   = cnt_q + CW'(1);
          end
`else
          state_d = DT;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    out_bits = OUT_IDLE;
    case (state_q)
      IDLE:    out_bits = OUT_IDLE;
      ST:      out_bits = OUT_ST;
      HD:      out_bits = OUT_HD;
      DP:      out_bits = OUT_DP;
      DT:      out_bits = OUT_DT;
      default: out_bits = OUT_IDLE;
    endcase
  end

  assign {start_o, clr_o, y_o, y_pulse_o} = out_bits;

endmodule

// File: rtl/fsm_hold_detect.sv
// Multi-channel hold detector: CHANNELS independent hold-detect FSMs plus ANY_Y.
// Optional feature macro: FSM_HOLD_AUTOREPEAT_EN (handled inside each channel).
module fsm_hold_detect
  import fsm_hold_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int HOLD_CYCLES   = 4,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [CHANNELS-1:0] X,
  output logic [CHANNELS-1:0] START,
  output logic [CHANNELS-1:0] CLR,
  output logic [CHANNELS-1:0] Y,
  output logic [CHANNELS-1:0] Y_PULSE,
  output logic                ANY_Y
);

  if (CHANNELS < 1) begin : g_param_check
    $error("fsm_hold_detect: CHANNELS must be >= 1");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    fsm_hold_channel #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk_i    (CLK),
      .rst_i    (RESET),
      .x_i      (X[c]),
      .start_o  (START[c]),
      .clr_o    (CLR[c]),
      .y_o      (Y[c]),
      .y_pulse_o(Y_PULSE[c])
    );
  end

  assign ANY_Y = |Y;

endmodule

// File: tb/tb_fsm_hold_detect.sv
// Directed testbench for fsm_hold_detect (CHANNELS=4, HOLD_CYCLES=4, REPEAT_CYCLES=8).
// Expectations follow FSM_HOLD_AUTOREPEAT_EN if the build defines it.
module tb_fsm_hold_detect;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] X;
  logic [3:0] START, CLR, Y, Y_PULSE;
  logic       ANY_Y;

  int cmp_count = 0;
  int err_count = 0;

  fsm_hold_detect #(
    .CHANNELS     (4),
    .HOLD_CYCLES  (4),
    .REPEAT_CYCLES(8)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .X      (X),
    .START  (START),
    .CLR    (CLR),
    .Y      (Y),
    .Y_PULSE(Y_PULSE),
    .ANY_Y  (ANY_Y)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic go_idle();
    X = 4'b0000;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    X     = 4'b0000;
    #2;
    cmp_count++;
    if ({START, CLR, Y, Y_PULSE, ANY_Y} !== {4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0}) begin
      err_count++;
      $display("FAIL reset_initial: got START=%b CLR=%b Y=%b Y_PULSE=%b ANY_Y=%b, want 0000 1111 0000 0000 0",
               START, CLR, Y, Y_PULSE, ANY_Y);
    end
    tick();
    RESET = 1'b0;
    X[0] = 1'b1;
    repeat (4) tick();   // ST, HD c0, HD c1, HD c2
    cmp_count++;
    if (CLR[0] !== 1'b0 || START[0] !== 1'b0) begin
      err_count++;
      $display("FAIL reset_pre_hd: got START0=%b CLR0=%b, want 0 0", START[0], CLR[0]);
    end
    #2 RESET = 1'b1;
    #1;
    cmp_count++;
    if (CLR !== 4'b1111 || Y !== 4'b0000 || ANY_Y !== 1'b0 || START !== 4'b0000) begin
      err_count++;
      $display("FAIL reset_mid_hd: got CLR=%b Y=%b ANY_Y=%b START=%b, want 1111 0000 0 0000",
               CLR, Y, ANY_Y, START);
    end
    #1 RESET = 1'b0;
    tick();
    cmp_count++;
    if (START[0] !== 1'b1) begin
      err_count++;
      $display("FAIL reset_restart: got START0=%b, want 1", START[0]);
    end
    go_idle();
  endtask

  task automatic test_nominal();
    X[0] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      cmp_count++;
      if (START[0] !== (e == 1) || Y_PULSE[0] !== (e == 6) || Y[0] !== (e >= 6) || ANY_Y !== (e >= 6)) begin
        err_count++;
        $display("FAIL nominal_e%0d: got START0=%b Y_PULSE0=%b Y0=%b ANY_Y=%b, want %b %b %b %b",
                 e, START[0], Y_PULSE[0], Y[0], ANY_Y, (e == 1), (e == 6), (e >= 6), (e >= 6));
      end
    end
    X[0] = 1'b0;
    tick();
    cmp_count++;
    if (Y[0] !== 1'b0 || ANY_Y !== 1'b0 || CLR[0] !== 1'b1) begin
      err_count++;
      $display("FAIL nominal_release: got Y0=%b ANY_Y=%b CLR0=%b, want 0 0 1", Y[0], ANY_Y, CLR[0]);
    end
    go_idle();
  endtask

  task automatic test_short_press();
    X[1] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      cmp_count++;
      if (Y[1] !== 1'b0 || CLR[1] !== 1'b0) begin
        err_count++;
        $display("FAIL short_e%0d: got Y1=%b CLR1=%b, want 0 0", e, Y[1], CLR[1]);
      end
    end
    X[1] = 1'b0;
    tick();
    cmp_count++;
    if (CLR[1] !== 1'b1 || Y[1] !== 1'b0) begin
      err_count++;
      $display("FAIL short_release: got CLR1=%b Y1=%b, want 1 0", CLR[1], Y[1]);
    end
    repeat (4) tick();
    cmp_count++;
    if (Y[1] !== 1'b0 || Y_PULSE[1] !== 1'b0) begin
      err_count++;
      $display("FAIL short_after: got Y1=%b Y_PULSE1=%b, want 0 0", Y[1], Y_PULSE[1]);
    end
  endtask

  task automatic test_repress();
    X[2] = 1'b1;
    repeat (6) tick();
    cmp_count++;
    if (Y_PULSE[2] !== 1'b1) begin
      err_count++;
      $display("FAIL repress_first_dp: got Y_PULSE2=%b, want 1", Y_PULSE[2]);
    end
    X[2] = 1'b0;
    tick();
    cmp_count++;
    if (CLR[2] !== 1'b1 || Y[2] !== 1'b0) begin
      err_count++;
      $display("FAIL repress_drop: got CLR2=%b Y2=%b, want 1 0", CLR[2], Y[2]);
    end
    tick();
    X[2] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      cmp_count++;
      if (START[2] !== (e == 1) || Y_PULSE[2] !== (e == 6) || Y[2] !== (e >= 6)) begin
        err_count++;
        $display("FAIL repress_e%0d: got START2=%b Y_PULSE2=%b Y2=%b, want %b %b %b",
                 e, START[2], Y_PULSE[2], Y[2], (e == 1), (e == 6), (e >= 6));
      end
    end
    go_idle();
  endtask

  task automatic test_independence();
    X[0] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      if (e == 4) X[3] = 1'b1;
      tick();
      cmp_count++;
      if (Y_PULSE[0] !== (e == 6) || Y_PULSE[3] !== (e == 9) ||
          CLR[2:1] !== 2'b11 || START[2:1] !== 2'b00 || Y[2:1] !== 2'b00) begin
        err_count++;
        $display("FAIL indep_e%0d: got Y_PULSE=%b CLR=%b START=%b Y=%b, want Y_PULSE0=%b Y_PULSE3=%b CLR[2:1]=11",
                 e, Y_PULSE, CLR, START, Y, (e == 6), (e == 9));
      end
    end
    go_idle();
  endtask

  task automatic test_auto_repeat();
    logic exp_pulse;
    X[0] = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
`ifdef FSM_HOLD_AUTOREPEAT_EN
      exp_pulse = (e == 6) || (e == 15) || (e == 24);
`else
      exp_pulse = (e == 6);
`endif
      cmp_count++;
      if (Y_PULSE[0] !== exp_pulse || Y[0] !== (e >= 6)) begin
        err_count++;
        $display("FAIL repeat_e%0d: got Y_PULSE0=%b Y0=%b, want %b %b",
                 e, Y_PULSE[0], Y[0], exp_pulse, (e >= 6));
      end
    end
    go_idle();
    cmp_count++;
    if (CLR !== 4'b1111 || ANY_Y !== 1'b0) begin
      err_count++;
      $display("FAIL final_idle: got CLR=%b ANY_Y=%b, want 1111 0", CLR, ANY_Y);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_press();
    test_repress();
    test_independence();
    test_auto_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units, want completion");
    $fatal(1, "timeout");
  end

endmodule
